// File: rtl/ps2_cmd_sequencer.sv
// Host-to-device PS/2 command sequencer: kicks the controller between RX/TX modes,
// sends a command byte, waits for 0xFA. Resend path built only when PS2_CMD_RETRY_EN is defined.
module ps2_cmd_sequencer #(
    parameter int ACK_TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic [2:0] status,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    output logic       ps2_en,
    output logic       ps2_tx_rqst,
    output logic [7:0] ps2_tx_data,
    input  logic       ps2_valid,
    input  logic [7:0] ps2_rx_data,
    input  logic [3:0] ps2_flags
);

    localparam int             TW      = $clog2(ACK_TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TO_LAST = TW'(ACK_TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NAK      = 3'd1;
    localparam logic [2:0] ST_TIMEOUT  = 3'd2;
    localparam logic [2:0] ST_TX_ERR   = 3'd3;
    localparam logic [2:0] ST_BAD_RESP = 3'd4;

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;

    typedef enum logic [2:0] {
        S_RX_KICK  = 3'd0,
        S_RX_RUN   = 3'd1,
        S_TX_KICK  = 3'd2,
        S_TX_RUN   = 3'd3,
        S_ACK_KICK = 3'd4,
        S_ACK_WAIT = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [2:0]      status_q, status_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            done_q, done_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q, rx_err_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            ps2_en_q, ps2_en_d;
    logic            ps2_tx_rqst_q, ps2_tx_rqst_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            flag_s;
    logic            fail_s;
    logic [2:0]      fail_code_s;

`ifdef PS2_CMD_RETRY_EN
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);
    logic [3:0]      retry_q, retry_d;
`else
    logic            retry_unused_s;
    assign retry_unused_s = ^(4'(MAX_RETRIES));
`endif

    assign flag_s = |ps2_flags;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        status_d    = status_q;
        rx_data_d   = rx_data_q;
        to_cnt_d    = to_cnt_q;
        done_d      = 1'b0;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        fail_s      = 1'b0;
        fail_code_s = ST_OK;
`ifdef PS2_CMD_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            S_RX_KICK: begin
                state_d = S_RX_RUN;
            end
            S_RX_RUN: begin
                if (flag_s) begin
                    rx_err_d = 1'b1;
                end else if (ps2_valid) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = ps2_rx_data;
                end else begin
                    rx_valid_d = 1'b0;
                end
                // A command wins over a flag restart: TX_KICK restarts the controller anyway
                if (cmd_valid && cmd_ready_q) begin
                    tx_data_d = cmd_data;
                    state_d   = S_TX_KICK;
`ifdef PS2_CMD_RETRY_EN
                    retry_d   = 4'd0;
`endif
                end else if (flag_s) begin
                    state_d = S_RX_KICK;
                end else begin
                    state_d = S_RX_RUN;
                end
            end
            S_TX_KICK: begin
                state_d = S_TX_RUN;
            end
            S_TX_RUN: begin
                if (flag_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ST_TX_ERR;
                end else if (ps2_valid) begin
                    state_d = S_ACK_KICK;
                end else begin
                    state_d = S_TX_RUN;
                end
            end
            S_ACK_KICK: begin
                to_cnt_d = '0;
                state_d  = S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (flag_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ST_TIMEOUT;
                end else if (ps2_valid) begin
                    if (ps2_rx_data == BYTE_ACK) begin
                        done_d   = 1'b1;
                        status_d = ST_OK;
                        state_d  = S_RX_RUN;
                    end else if (ps2_rx_data == BYTE_RESEND) begin
                        fail_s      = 1'b1;
                        fail_code_s = ST_NAK;
                    end else begin
                        done_d   = 1'b1;
                        status_d = ST_BAD_RESP;
                        state_d  = S_RX_RUN;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    fail_s      = 1'b1;
                    fail_code_s = ST_TIMEOUT;
                end else begin
                    state_d = S_ACK_WAIT;
                end
            end
            default: begin
                state_d = S_RX_KICK;
            end
        endcase

        // Failure resolution: resend the same byte while attempts remain
        if (fail_s) begin
`ifdef PS2_CMD_RETRY_EN
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = S_TX_KICK;
            end else begin
                done_d   = 1'b1;
                status_d = fail_code_s;
                state_d  = S_RX_KICK;
            end
`else
            done_d   = 1'b1;
            status_d = fail_code_s;
            state_d  = S_RX_KICK;
`endif
        end else begin
            fail_code_s = fail_code_s;
        end

        ps2_en_d      = (state_d == S_RX_RUN) || (state_d == S_TX_RUN) || (state_d == S_ACK_WAIT);
        ps2_tx_rqst_d = (state_d == S_TX_KICK) || (state_d == S_TX_RUN);
        cmd_ready_d   = (state_d == S_RX_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RX_KICK;
            tx_data_q     <= 8'h00;
            status_q      <= 3'd0;
            rx_data_q     <= 8'h00;
            to_cnt_q      <= '0;
            done_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_err_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            ps2_en_q      <= 1'b0;
            ps2_tx_rqst_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            status_q      <= status_d;
            rx_data_q     <= rx_data_d;
            to_cnt_q      <= to_cnt_d;
            done_q        <= done_d;
            rx_valid_q    <= rx_valid_d;
            rx_err_q      <= rx_err_d;
            cmd_ready_q   <= cmd_ready_d;
            ps2_en_q      <= ps2_en_d;
            ps2_tx_rqst_q <= ps2_tx_rqst_d;
        end
    end

`ifdef PS2_CMD_RETRY_EN
    // Resend attempt counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 4'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign cmd_ready   = cmd_ready_q;
    assign done        = done_q;
    assign status      = status_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_err      = rx_err_q;
    assign ps2_en      = ps2_en_q;
    assign ps2_tx_rqst = ps2_tx_rqst_q;
    assign ps2_tx_data = tx_data_q;

endmodule

// File: doc/ps2_cmd_sequencer.md
# ps2_cmd_sequencer

Sequences host-to-device PS/2 command transactions on top of the PS/2 controller. It switches the controller between receive and transmit mode, sends a command byte and waits for the device acknowledge (0xFA). It retries on resend (0xFE), errors or timeout. Between commands it runs the controller in receive mode and forwards scancodes. It sits between the PS/2 controller and the host-side command/scancode logic.

## Interface
- ACK_TIMEOUT_CYCLES, 1_000_000: clk cycles allowed for the ack byte after transmit completes (20 ms at 50 MHz); must be ≥ 2.
- MAX_RETRIES, 3: resends allowed after the first attempt; total attempts = MAX_RETRIES+1; range 0..15.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in RX_RUN; transfer when cmd_valid & cmd_ready.
- cmd_data  in  8  command byte, sampled on transfer.
- done  out  1  one-cycle pulse at command completion.
- status  out  3  result, valid with done and held until the next done:
  - 0 OK
  - 1 NAK (resends exhausted)
  - 2 TIMEOUT
  - 3 TX_ERR (controller flag during transmit)
  - 4 BAD_RESP (byte other than 0xFA/0xFE)
- rx_valid  out  1  one-cycle pulse, scancode received in RX_RUN.
- rx_data  out  8  scancode, valid with rx_valid, held afterwards.
- rx_err  out  1  one-cycle pulse when a controller flag aborts a reception in RX_RUN.
- ps2_en  out  1  controller enable; a 0→1 edge (re)starts it in the mode given by ps2_tx_rqst.
- ps2_tx_rqst  out  1  controller mode: 1 transmit, 0 receive.
- ps2_tx_data  out  8  byte to transmit, registered.
- ps2_valid  in  1  controller pulse: byte received (RX mode) or transmit finished (TX mode).
- ps2_rx_data  in  8  received byte, valid with ps2_valid.
- ps2_flags  in  4  {rqst_timeout, clk_timeout, parity_error, frame_error}; any bit set = error.

## Operation
- Reset state RX_KICK; all outputs 0; retry counter 0; timeout counter 0.
- Controller restart rule: every mode entry passes through a KICK state. A KICK state drives ps2_en=0 for exactly one cycle with the new ps2_tx_rqst value. The following state drives ps2_en=1.
- RX_KICK → RX_RUN: ps2_en=0, ps2_tx_rqst=0.
- RX_RUN: ps2_en=1, cmd_ready=1.
  - ps2_valid & no flag → rx_valid pulse with rx_data=ps2_rx_data.
  - Any flag → rx_err pulse and go to RX_KICK.
  - Command transfer → latch cmd_data into ps2_tx_data, clear the retry counter, go to TX_KICK. Any partial reception is abandoned.
- TX_KICK → TX_RUN: ps2_en=0, ps2_tx_rqst=1.
- TX_RUN: ps2_en=1. Exit on ps2_valid.
  - Flag set → failure TX_ERR.
  - No flag → ACK_KICK.
- ACK_KICK → ACK_WAIT: ps2_en=0, ps2_tx_rqst=0, timeout counter cleared.
- ACK_WAIT: ps2_en=1, counter increments each cycle.
  - ps2_valid & no flag with 0xFA → done, status OK, go to RX_RUN directly (controller already in RX mode).
  - ps2_valid & no flag with 0xFE → failure NAK.
  - ps2_valid & no flag with any other byte → done, status BAD_RESP, no retry, go to RX_RUN. The byte is not forwarded.
  - Flag set or counter reaches ACK_TIMEOUT_CYCLES-1 → failure TIMEOUT.
- Failure handling:
  - If retry counter < MAX_RETRIES: increment it and go to TX_KICK with the same ps2_tx_data.
  - Otherwise: done with that failure's status, then go to RX_KICK.
- ps2_valid and a flag in the same cycle count as the flag case.
- Asynchronous reset mid-transaction: immediate return to the reset state. No done is issued for the aborted command.

## Timing
- Transfer at cycle N: TX_KICK at N+1, ps2_en rises at N+2.
- Transmit finished with ps2_valid at cycle M: ACK_KICK at M+1, ACK_WAIT from M+2.
- done, status, rx_valid and rx_err are registered: asserted the cycle after the causing ps2_valid, flag or timeout.
- In RX_RUN, ps2_valid and cmd transfer in the same cycle: the scancode is forwarded and the command accepted.
- Timeout counter width is $clog2(ACK_TIMEOUT_CYCLES). It never wraps because it is cleared on every ACK_KICK.

## Configuration
- PS2_CMD_RETRY_EN defined: retry counter and resend path as described.
- Undefined: MAX_RETRIES is ignored and no retry counter is built. The first TX_ERR, NAK or TIMEOUT ends the command immediately with that status.

## Test plan
- Reset, then the device sends 0x1C: rx_valid pulses once with rx_data=0x1C; done stays 0.
- cmd 0xED, transmit ok, device replies 0xFA: ps2_en low exactly one cycle before TX_RUN and before ACK_WAIT; done with status 0; cmd_ready high again the next cycle.
- cmd 0xFF, device replies 0xFE four times (MAX_RETRIES=3): four transmits of 0xFF; done with status 1. With the macro undefined: one transmit, status 1.
- cmd 0xF4, no reply, ACK_TIMEOUT_CYCLES=100: done with status 2 after 4 × (transmit + 100 cycles).
- cmd 0xF3, ps2_flags=0001 with ps2_valid in TX_RUN on every attempt: done with status 3. Device replies 0xAA: done with status 4 and no retry.
- RX_RUN with parity flag: rx_err pulse, ps2_en low one cycle, then reception resumes. Reset asserted during ACK_WAIT: all outputs 0, no done.
